// File: rtl/spike_feeder.sv
// spike_feeder: rate-coding front end for the spiking network.
// Latches one pixel frame, starts the network, then answers every sample
// request with a Bernoulli spike vector (pixel > pseudo-random threshold).
module spike_feeder #(
   parameter int          N_INPUTS  = 4,
   parameter int          PIX_W     = 8,
   parameter int          N_CYCLES  = 10,
   parameter int          CNT_W     = 5,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      frame_valid,
   output logic                      frame_ready,
   input  logic [N_INPUTS*PIX_W-1:0] pixels,
   input  logic                      net_ready,
   output logic                      start,
   input  logic                      sample,
   output logic                      sample_ready,
   output logic [N_INPUTS-1:0]       in_spikes,
   output logic                      done
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_START = 2'd1;
   localparam logic [1:0] S_SERVE = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]                state_q, state_d;
   logic [N_INPUTS*PIX_W-1:0] pix_q, pix_d;
   logic [15:0]               lfsr_q, lfsr_d;
   logic [CNT_W-1:0]          count_q, count_d;
   logic [N_INPUTS-1:0]       spikes_q, spikes_d;
   logic                      start_q, start_d;
   logic                      srdy_q, srdy_d;
   logic                      done_q, done_d;
   logic                      accept;
   logic                      last_req;

   // Fibonacci LFSR x^16+x^14+x^13+x^11+1, shifting left, feedback into bit 0.
   function automatic logic [15:0] lfsr_step(input logic [15:0] l);
      return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
   endfunction

   // Each lane compares its intensity against a window of the doubled LFSR
   // word starting at bit (3*i)%16, so lanes see decorrelated thresholds.
   function automatic logic [N_INPUTS-1:0] rate_code(input logic [15:0] l,
                                                     input logic [N_INPUTS*PIX_W-1:0] pix);
      logic [31:0]         d;
      logic [PIX_W-1:0]    rnd;
      logic [PIX_W-1:0]    p;
      logic [N_INPUTS-1:0] r;
      d = {l, l};
      r = '0;
      for (int i = 0; i < N_INPUTS; i++) begin
         rnd  = d[(3*i)%16 +: PIX_W];
         p    = pix[i*PIX_W +: PIX_W];
         r[i] = (p > rnd);
      end
      return r;
   endfunction

   // A request is taken only when no response is currently being shown,
   // which is what paces a held-high sample to one response every 2 cycles.
   assign accept   = sample && !srdy_q;
   assign last_req = (count_q == CNT_W'(N_CYCLES - 1));

   assign frame_ready  = rst_n && (state_q == S_IDLE);
   assign start        = start_q;
   assign sample_ready = srdy_q;
   assign in_spikes    = spikes_q;
   assign done         = done_q;

   // Next-state logic; start/sample_ready/done are single-cycle pulses.
   always_comb begin
      state_d  = state_q;
      pix_d    = pix_q;
      lfsr_d   = lfsr_q;
      count_d  = count_q;
      spikes_d = spikes_q;
      start_d  = 1'b0;
      srdy_d   = 1'b0;
      done_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (frame_valid) begin
               pix_d   = pixels;
               state_d = S_START;
            end
         end
         S_START: begin
            if (net_ready) begin
               start_d = 1'b1;
               state_d = S_SERVE;
            end
         end
         S_SERVE: begin
            if (accept) begin
               spikes_d = rate_code(lfsr_q, pix_q);
               srdy_d   = 1'b1;
               lfsr_d   = lfsr_step(lfsr_q);
               count_d  = count_q + CNT_W'(1);
               if (last_req) state_d = S_DONE;
            end
         end
         default: begin
            done_d   = 1'b1;
            spikes_d = '0;
            count_d  = '0;
            state_d  = S_IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         pix_q    <= '0;
         lfsr_q   <= LFSR_SEED;
         count_q  <= '0;
         spikes_q <= '0;
         start_q  <= 1'b0;
         srdy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         pix_q    <= pix_d;
         lfsr_q   <= lfsr_d;
         count_q  <= count_d;
         spikes_q <= spikes_d;
         start_q  <= start_d;
         srdy_q   <= srdy_d;
         done_q   <= done_d;
      end
   end

endmodule

// File: tb/tb_spike_feeder.sv
// Directed + randomized bench for spike_feeder with an arithmetic reference model.
module tb_spike_feeder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        frame_valid;
   logic        frame_ready;
   logic [31:0] pixels;
   logic        net_ready;
   logic        start;
   logic        sample;
   logic        sample_ready;
   logic [3:0]  in_spikes;
   logic        done;

   int tests = 0;
   int fails = 0;

   int         ref_l;
   int         ref_pix [4];
   logic [3:0] tb_last;
   int         served;
   logic [3:0] first_vec;

   spike_feeder dut (
      .clk(clk), .rst_n(rst_n),
      .frame_valid(frame_valid), .frame_ready(frame_ready), .pixels(pixels),
      .net_ready(net_ready), .start(start),
      .sample(sample), .sample_ready(sample_ready), .in_spikes(in_spikes),
      .done(done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference LFSR: next value computed with integer arithmetic on taps 16,14,13,11.
   function automatic int ref_next(input int l);
      int fb;
      fb = ((l >> 15) ^ (l >> 13) ^ (l >> 12) ^ (l >> 10)) & 1;
      return ((l << 1) | fb) & 32'hFFFF;
   endfunction

   // Reference spike vector: lane i spikes when its pixel exceeds the 8-bit
   // threshold taken from the duplicated LFSR word at offset (3*i) mod 16.
   function automatic logic [3:0] ref_spikes();
      longint     dd;
      int         rnd;
      logic [3:0] v;
      dd = (longint'(ref_l) << 16) | longint'(ref_l);
      for (int i = 0; i < 4; i++) begin
         rnd  = int'((dd >> ((3 * i) % 16)) & 64'hFF);
         v[i] = (ref_pix[i] > rnd);
      end
      return v;
   endfunction

   task automatic do_reset();
      rst_n = 1'b0; frame_valid = 1'b0; sample = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("rst_start", start, 0);
      chk("rst_sready", sample_ready, 0);
      chk("rst_spikes", in_spikes, 0);
      chk("rst_done", done, 0);
      chk("rst_fready", frame_ready, 0);
      rst_n = 1'b1;
      ref_l = 32'hACE1;
      #1;
      chk("post_rst_fready", frame_ready, 1);
   endtask

   task automatic send_frame(input logic [31:0] pix);
      @(negedge clk);
      pixels = pix; frame_valid = 1'b1;
      chk("fready_idle", frame_ready, 1);
      for (int i = 0; i < 4; i++) ref_pix[i] = int'((pix >> (8 * i)) & 32'hFF);
      @(negedge clk);
      frame_valid = 1'b0;
      pixels = $urandom;
      chk("fready_busy", frame_ready, 0);
   endtask

   task automatic wait_start(input int budget);
      bit seen;
      seen = 1'b0;
      for (int c = 0; c < budget && !seen; c++) begin
         if (start === 1'b1) seen = 1'b1;
         else @(negedge clk);
      end
      chk("start_seen", seen, 1);
      @(negedge clk);
      chk("start_one_cycle", start, 0);
      tb_last = 4'h0;
      served  = 0;
      @(posedge clk);
      #1;
   endtask

   task automatic serve(input int n, input bit finish);
      logic [3:0] e;
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         chk("sready_low", sample_ready, 0);
         chk("spikes_hold", in_spikes, tb_last);
         chk("done_low", done, 0);
         sample = 1'b1;
         @(negedge clk);
         chk("sready_pulse", sample_ready, 1);
         e = ref_spikes();
         chk("spikes", in_spikes, e);
         if (served == 0) first_vec = in_spikes;
         served++;
         tb_last = e;
         ref_l = ref_next(ref_l);
         sample = 1'b0;
      end
      if (finish) begin
         @(negedge clk);
         chk("done_pulse", done, 1);
         chk("done_spikes_clr", in_spikes, 0);
         chk("done_sready", sample_ready, 0);
         chk("done_fready", frame_ready, 1);
      end
   endtask

   initial begin
      int         pulses;
      logic [3:0] e;
      bit         exp_sr;
      rst_n = 1'b0; frame_valid = 1'b0; pixels = '0; net_ready = 1'b1; sample = 1'b0;

      // 1: zero pixels never spike
      do_reset();
      send_frame(32'h0000_0000);
      wait_start(10);
      serve(10, 1'b1);
      @(negedge clk);
      chk("t1_done_one_cycle", done, 0);

      // 2: saturated pixels from seed
      do_reset();
      send_frame(32'hFFFF_FFFF);
      wait_start(10);
      serve(10, 1'b1);
      chk("t2_lane0_first", first_vec[0], 1);
      chk("t2_first_vec", first_vec, 4'hF);

      // 3: sample held high for 30 cycles
      send_frame(32'h8040_C0FF);
      wait_start(10);
      pulses = 0;
      @(negedge clk);
      sample = 1'b1;
      for (int k = 1; k <= 30; k++) begin
         @(negedge clk);
         exp_sr = (k % 2 == 1) && (k <= 19);
         chk("t3_sready", sample_ready, exp_sr);
         if (sample_ready === 1'b1) begin
            pulses++;
            e = ref_spikes();
            chk("t3_spikes", in_spikes, e);
            ref_l = ref_next(ref_l);
         end
         if (k == 20) chk("t3_done", done, 1);
      end
      sample = 1'b0;
      chk("t3_pulses", pulses, 10);

      // 4: network busy after frame accept
      net_ready = 1'b0;
      send_frame(32'h1234_5678);
      for (int c = 0; c < 20; c++) begin
         sample = c[0];
         @(negedge clk);
         chk("t4_no_start", start, 0);
         chk("t4_no_sready", sample_ready, 0);
         chk("t4_no_spikes", in_spikes, 0);
      end
      sample = 1'b0;
      net_ready = 1'b1;
      @(negedge clk);
      chk("t4_start", start, 1);
      @(negedge clk);
      chk("t4_start_drop", start, 0);
      tb_last = 4'h0; served = 0;
      serve(10, 1'b1);

      // 5: reset mid-serve restarts the LFSR sequence
      do_reset();
      send_frame(32'hFFFF_FFFF);
      wait_start(10);
      serve(4, 1'b0);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("t5_start", start, 0);
      chk("t5_sready", sample_ready, 0);
      chk("t5_spikes", in_spikes, 0);
      chk("t5_done", done, 0);
      rst_n = 1'b1;
      ref_l = 32'hACE1;
      send_frame(32'hFFFF_FFFF);
      wait_start(10);
      serve(10, 1'b1);
      chk("t5_first_vec", first_vec, 4'hF);

      // 6: frame offered during SERVE is held off until done
      send_frame(32'h9A3C_5F71);
      wait_start(10);
      serve(3, 1'b0);
      @(negedge clk);
      pixels = 32'h0102_0304; frame_valid = 1'b1;
      #1;
      chk("t6_fready_busy", frame_ready, 0);
      serve(7, 1'b1);
      for (int i = 0; i < 4; i++) ref_pix[i] = int'((32'h0102_0304 >> (8 * i)) & 32'hFF);
      @(negedge clk);
      frame_valid = 1'b0;
      chk("t6_second_accepted", frame_ready, 0);
      wait_start(10);
      serve(10, 1'b1);

      // 7: random frames, random network readiness delay
      for (int f = 0; f < 4; f++) begin
         net_ready = 1'b0;
         send_frame($urandom);
         repeat ($urandom_range(0, 5)) @(negedge clk);
         net_ready = 1'b1;
         wait_start(20);
         serve(10, 1'b1);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
